// File: rtl/px_bist_pkg.sv
// -----------------------------------------------------------------------------
// px_bist_pkg
// Shared types and helpers for the pixel-pipeline BIST sequencer:
//   - bist_state_t : sequencer FSM states
//   - DEF_LFSR_POLY / DEF_MISR_POLY : default feedback masks
//   - lfsr_next()  : one step of a right-shifting Galois LFSR
//   - misr_next()  : one step of a left-shifting MISR with data fold-in
// Both helpers work on MAX_W-bit containers. Callers zero-extend narrower
// operands into the container and truncate the result back to their width.
// -----------------------------------------------------------------------------
package px_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    localparam logic [7:0]  DEF_LFSR_POLY = 8'hB8;
    localparam logic [15:0] DEF_MISR_POLY = 16'h1021;

    // Widest LFSR / signature either helper supports.
    localparam int MAX_W = 64;

    // Right shift keeps unused upper container bits at zero, so the result is
    // correct for any width up to MAX_W without knowing that width.
    function automatic logic [MAX_W-1:0] lfsr_next(
        input logic [MAX_W-1:0] s,
        input logic [MAX_W-1:0] poly
    );
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction

    // The feedback tap is the top bit of the real signature width, selected
    // with a mask so the index never has to be narrowed.
    function automatic logic [MAX_W-1:0] misr_next(
        input logic [MAX_W-1:0] sig,
        input logic [MAX_W-1:0] poly,
        input logic [MAX_W-1:0] data,
        input int               width
    );
        logic [MAX_W-1:0] top_mask;
        logic             msb;
        top_mask = {{(MAX_W-1){1'b0}}, 1'b1} << (width - 1);
        msb      = |(sig & top_mask);
        return (sig << 1) ^ (msb ? poly : '0) ^ data;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
// Parametrised multiple-input signature register. Each enabled cycle folds one
// data word into the signature: sig' = (sig<<1) ^ (msb ? POLY : 0) ^ data.
// Ports:
//   clk_i    in  1       clock
//   reset_i  in  1       synchronous reset, active-high (signature -> 0)
//   clr_i    in  1       synchronous clear (signature -> 0), wins over en_i
//   en_i     in  1       fold data_i into the signature this cycle
//   data_i   in  DATA_W  word to compact (zero-extended to SIG_W)
//   sig_o    out SIG_W   current signature (registered)
// -----------------------------------------------------------------------------
module bist_misr
    import px_bist_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_MISR_POLY)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [SIG_W-1:0]  sig_o
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_data_ext;
    logic [SIG_W-1:0] w_sig_next;

    // Zero-extend the data word to the signature width bit by bit.
    for (genvar gi = 0; gi < SIG_W; gi++) begin : g_ext
        if (gi < DATA_W) begin : g_in
            assign w_data_ext[gi] = data_i[gi];
        end else begin : g_pad
            assign w_data_ext[gi] = 1'b0;
        end
    end

    assign w_sig_next = SIG_W'(misr_next(MAX_W'(r_sig), MAX_W'(POLY),
                                         MAX_W'(w_data_ext), SIG_W));

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            r_sig <= '0;
        end else if (en_i) begin
            r_sig <= w_sig_next;
        end
    end

    assign sig_o = r_sig;

endmodule

// File: rtl/px_bist_sequencer.sv
// -----------------------------------------------------------------------------
// px_bist_sequencer
// Self-timed BIST for the grayscale/Sobel pipeline. On start it issues
// FRAME_LEN pseudo-random pixels from a Galois LFSR (one every ISSUE_GAP+1
// cycles), compacts the pipeline's returned beats in a MISR and compares the
// final signature with a golden value latched at start.
// Ports:
//   clk_i        in  1         clock
//   reset_i      in  1         synchronous reset, active-high
//   start_i      in  1         begin a run (accepted in IDLE or DONE)
//   abort_i      in  1         return to IDLE from any state, wins over start
//   seed_i       in  PX_IN_W   LFSR seed (zero is replaced by 1)
//   golden_i     in  SIG_W     expected signature
//   px_o         out PX_IN_W   stimulus pixel
//   px_rdy_o     out 1         one-cycle strobe qualifying px_o
//   dut_px_i     in  PX_OUT_W  pipeline output pixel
//   dut_rdy_i    in  1         pipeline output strobe
//   busy_o       out 1         in RUN or DRAIN
//   done_o       out 1         in DONE
//   pass_o       out 1         signature matched, no timeout, no overflow
//   timeout_o    out 1         drain ran out of time
//   overflow_o   out 1         more than OUT_LEN beats arrived
//   signature_o  out SIG_W     current MISR value
// -----------------------------------------------------------------------------
module px_bist_sequencer
    import px_bist_pkg::*;
#(
    parameter int                 PX_IN_W   = 8,
    parameter int                 PX_OUT_W  = 8,
    parameter int                 SIG_W     = 16,
    parameter logic [PX_IN_W-1:0] LFSR_POLY = PX_IN_W'(DEF_LFSR_POLY),
    parameter logic [SIG_W-1:0]   MISR_POLY = SIG_W'(DEF_MISR_POLY),
    parameter int                 FRAME_LEN = 64,
    parameter int                 OUT_LEN   = FRAME_LEN,
    parameter int                 ISSUE_GAP = 0,
    parameter int                 DRAIN_TO  = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [PX_IN_W-1:0]  seed_i,
    input  logic [SIG_W-1:0]    golden_i,
    output logic [PX_IN_W-1:0]  px_o,
    output logic                px_rdy_o,
    input  logic [PX_OUT_W-1:0] dut_px_i,
    input  logic                dut_rdy_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic                timeout_o,
    output logic                overflow_o,
    output logic [SIG_W-1:0]    signature_o
);

    localparam int ISS_W = $clog2(FRAME_LEN) + 1;
    localparam int RCV_W = $clog2(OUT_LEN) + 1;
    localparam int GAP_W = $clog2(ISSUE_GAP + 1) + 1;
    localparam int TO_W  = $clog2(DRAIN_TO) + 1;

    bist_state_t        r_state;
    bist_state_t        w_state_next;
    logic [PX_IN_W-1:0] r_lfsr;       // next pixel to issue
    logic [PX_IN_W-1:0] r_px;
    logic               r_px_rdy;
    logic [SIG_W-1:0]   r_golden;
    logic [ISS_W-1:0]   r_iss_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [RCV_W-1:0]   r_rcv_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_timeout;
    logic               r_overflow;

    logic               w_start;
    logic               w_issue;
    logic               w_to_hit;
    logic               w_active;
    logic               w_rcv_full;
    logic               w_count_beat;
    logic               w_ovf_beat;
    logic [PX_IN_W-1:0] w_seed_eff;
    logic [PX_IN_W-1:0] w_issue_px;
    logic [PX_IN_W-1:0] w_lfsr_next;
    logic [SIG_W-1:0]   w_sig;

    assign w_seed_eff  = (seed_i == '0) ? PX_IN_W'(1) : seed_i;
    // The very first pixel comes straight from the seed so that it can be on
    // px_o in the cycle right after start is sampled.
    assign w_issue_px  = w_start ? w_seed_eff : r_lfsr;
    assign w_lfsr_next = PX_IN_W'(lfsr_next(MAX_W'(w_issue_px), MAX_W'(LFSR_POLY)));

    // Next-state and per-cycle control.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_issue      = 1'b0;
        w_to_hit     = 1'b0;
        w_active     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        w_rcv_full   = (r_rcv_cnt == RCV_W'(OUT_LEN));
        w_count_beat = w_active && dut_rdy_i && !w_rcv_full && !abort_i;
        w_ovf_beat   = w_active && dut_rdy_i &&  w_rcv_full && !abort_i;

        if (abort_i) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        w_state_next = ST_RUN;
                        w_start      = 1'b1;
                        w_issue      = 1'b1;
                    end
                end
                ST_RUN: begin
                    // A full receive count ends the run even mid-frame; the
                    // overflow flag is what reports that situation.
                    if (w_rcv_full) begin
                        w_state_next = ST_DONE;
                    end else if (r_iss_cnt == ISS_W'(FRAME_LEN)) begin
                        w_state_next = ST_DRAIN;
                    end else if (r_gap_cnt == '0) begin
                        w_issue = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_rcv_full) begin
                        w_state_next = ST_DONE;
                    end else if (!w_count_beat && (r_to_cnt == TO_W'(DRAIN_TO - 1))) begin
                        w_state_next = ST_DONE;
                        w_to_hit     = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_lfsr     <= '0;
            r_px       <= '0;
            r_px_rdy   <= 1'b0;
            r_golden   <= '0;
            r_iss_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_rcv_cnt  <= '0;
            r_to_cnt   <= '0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_px_rdy <= w_issue;

            if (w_issue) begin
                r_px   <= w_issue_px;
                r_lfsr <= w_lfsr_next;
            end

            if (w_start) begin
                r_golden   <= golden_i;
                r_iss_cnt  <= ISS_W'(1);
                r_gap_cnt  <= GAP_W'(ISSUE_GAP);
                r_rcv_cnt  <= '0;
                r_to_cnt   <= '0;
                r_timeout  <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_iss_cnt <= r_iss_cnt + ISS_W'(1);
                    r_gap_cnt <= GAP_W'(ISSUE_GAP);
                end else if ((r_state == ST_RUN) && (r_gap_cnt != '0)) begin
                    r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                end

                if (w_count_beat) begin
                    r_rcv_cnt <= r_rcv_cnt + RCV_W'(1);
                end
                if (w_ovf_beat) begin
                    r_overflow <= 1'b1;
                end
                if (w_to_hit) begin
                    r_timeout <= 1'b1;
                end

                // Counts consecutive beat-less DRAIN cycles.
                if (w_count_beat || ((r_state == ST_RUN) && (w_state_next == ST_DRAIN))) begin
                    r_to_cnt <= '0;
                end else if (r_state == ST_DRAIN) begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end
        end
    end

    bist_misr #(
        .DATA_W (PX_OUT_W),
        .SIG_W  (SIG_W),
        .POLY   (MISR_POLY)
    ) u_misr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (w_start),
        .en_i    (w_count_beat),
        .data_i  (dut_px_i),
        .sig_o   (w_sig)
    );

    // Decoded only from registers, so no input reaches these outputs
    // combinationally.
    assign px_o        = r_px;
    assign px_rdy_o    = r_px_rdy;
    assign busy_o      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done_o      = (r_state == ST_DONE);
    assign pass_o      = (r_state == ST_DONE) && (w_sig == r_golden) && !r_timeout && !r_overflow;
    assign timeout_o   = r_timeout;
    assign overflow_o  = r_overflow;
    assign signature_o = w_sig;

endmodule

// File: tb/tb_px_bist_sequencer.sv
module tb_px_bist_sequencer;

    localparam int A_F  = 6;
    localparam int A_O  = 4;
    localparam int A_G  = 0;
    localparam int A_TO = 5;
    localparam int MAXC = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUT A: FRAME 6, OUT 4, GAP 0, DRAIN_TO 5 ----------------
    logic        a_start, a_abort, a_dut_rdy;
    logic [7:0]  a_seed, a_dut_px, a_px;
    logic [15:0] a_golden, a_sig;
    logic        a_px_rdy, a_busy, a_done, a_pass, a_to, a_ov;

    px_bist_sequencer #(
        .PX_IN_W(8), .PX_OUT_W(8), .SIG_W(16), .LFSR_POLY(8'hB8), .MISR_POLY(16'h1021),
        .FRAME_LEN(A_F), .OUT_LEN(A_O), .ISSUE_GAP(A_G), .DRAIN_TO(A_TO)
    ) u_a (
        .clk_i(clk), .reset_i(reset), .start_i(a_start), .abort_i(a_abort),
        .seed_i(a_seed), .golden_i(a_golden), .px_o(a_px), .px_rdy_o(a_px_rdy),
        .dut_px_i(a_dut_px), .dut_rdy_i(a_dut_rdy), .busy_o(a_busy), .done_o(a_done),
        .pass_o(a_pass), .timeout_o(a_to), .overflow_o(a_ov), .signature_o(a_sig)
    );

    // ---------------- DUT B: FRAME 3, OUT 3, GAP 2, DRAIN_TO 4 ----------------
    logic        b_start, b_abort, b_dut_rdy;
    logic [7:0]  b_seed, b_dut_px, b_px;
    logic [15:0] b_golden, b_sig;
    logic        b_px_rdy, b_busy, b_done, b_pass, b_to, b_ov;

    px_bist_sequencer #(
        .PX_IN_W(8), .PX_OUT_W(8), .SIG_W(16), .LFSR_POLY(8'hB8), .MISR_POLY(16'h1021),
        .FRAME_LEN(3), .OUT_LEN(3), .ISSUE_GAP(2), .DRAIN_TO(4)
    ) u_b (
        .clk_i(clk), .reset_i(reset), .start_i(b_start), .abort_i(b_abort),
        .seed_i(b_seed), .golden_i(b_golden), .px_o(b_px), .px_rdy_o(b_px_rdy),
        .dut_px_i(b_dut_px), .dut_rdy_i(b_dut_rdy), .busy_o(b_busy), .done_o(b_done),
        .pass_o(b_pass), .timeout_o(b_to), .overflow_o(b_ov), .signature_o(b_sig)
    );

    // ---------------- DUT C: FRAME 1, OUT 1, loopback ----------------
    logic        c_start, c_abort, c_dut_rdy;
    logic [7:0]  c_seed, c_dut_px, c_px;
    logic [15:0] c_golden, c_sig;
    logic        c_px_rdy, c_busy, c_done, c_pass, c_to, c_ov;

    assign c_dut_rdy = c_px_rdy;
    assign c_dut_px  = c_px;

    px_bist_sequencer #(
        .PX_IN_W(8), .PX_OUT_W(8), .SIG_W(16), .LFSR_POLY(8'hB8), .MISR_POLY(16'h1021),
        .FRAME_LEN(1), .OUT_LEN(1), .ISSUE_GAP(0), .DRAIN_TO(8)
    ) u_c (
        .clk_i(clk), .reset_i(reset), .start_i(c_start), .abort_i(c_abort),
        .seed_i(c_seed), .golden_i(c_golden), .px_o(c_px), .px_rdy_o(c_px_rdy),
        .dut_px_i(c_dut_px), .dut_rdy_i(c_dut_rdy), .busy_o(c_busy), .done_o(c_done),
        .pass_o(c_pass), .timeout_o(c_to), .overflow_o(c_ov), .signature_o(c_sig)
    );

    // Stimulus beat schedule for DUT A, indexed by cycle (1 = first RUN cycle).
    logic       m_rdy [0:MAXC];
    logic [7:0] m_px  [0:MAXC];

    typedef struct {
        logic [7:0] seed;
        logic [7:0] px0;
        logic [7:0] px1;
    } seed_vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_misr(input logic [15:0] sig, input logic [7:0] px);
        int s;
        s = (int'(sig) * 2) % 65536;
        if (sig >= 16'h8000) s = s ^ 'h1021;
        return 16'(s ^ int'(px));
    endfunction

    function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
        int v;
        v = int'(s) / 2;
        if (s % 2 == 1) v = v ^ 'hB8;
        return 8'(v);
    endfunction

    // Walk the schedule with the run rules: counted beats until OUT_LEN, then
    // one more cycle (where a beat means overflow); beat-less DRAIN cycles
    // accumulate toward the timeout.
    task automatic model_a(output int done_c, output logic [15:0] sig,
                           output bit to, output bit ov);
        int n, q, t_d;
        n = 0; q = 0; sig = '0; to = 0; ov = 0; done_c = MAXC;
        t_d = 1 + (A_F - 1) * (A_G + 1) + 1;
        for (int c = 1; c < MAXC; c++) begin
            if (n == A_O) begin
                if (m_rdy[c]) ov = 1;
                done_c = c + 1;
                break;
            end
            if (m_rdy[c]) begin
                sig = ref_misr(sig, m_px[c]);
                n++;
                q = 0;
            end else if (c >= t_d) begin
                q++;
                if (q == A_TO) begin
                    to = 1;
                    done_c = c + 1;
                    break;
                end
            end
        end
    endtask

    // mode 0 random, 1 timeout, 2 overflow, 3 early exit in RUN, 4 exact count
    task automatic run_a(input int mode, input logic [7:0] seed, input bit good_golden);
        int          done_c, idx;
        logic [15:0] sig, golden;
        bit          to, ov, pass, exp_rdy;
        logic [7:0]  exp_px [A_F];
        logic [7:0]  s;
        int          cutoff, dens;

        for (int c = 0; c <= MAXC; c++) begin
            m_rdy[c] = 1'b0;
            m_px[c]  = 8'($urandom);
        end
        case (mode)
            0: begin
                cutoff = $urandom_range(4, 30);
                dens   = $urandom_range(1, 4);
                for (int c = 0; c <= cutoff; c++) m_rdy[c] = ($urandom_range(0, 3) < dens);
            end
            1: for (int c = 7; c <= 9; c++)  m_rdy[c] = 1'b1;
            2: for (int c = 7; c <= 11; c++) m_rdy[c] = 1'b1;
            3: for (int c = 1; c <= 4; c++)  m_rdy[c] = 1'b1;
            default: for (int c = 8; c <= 11; c++) m_rdy[c] = 1'b1;
        endcase

        model_a(done_c, sig, to, ov);
        golden = good_golden ? sig : (sig ^ 16'(($urandom % 65535) + 1));
        pass   = (sig == golden) && !to && !ov;
        s = (seed == 8'h00) ? 8'h01 : seed;
        for (int i = 0; i < A_F; i++) begin
            exp_px[i] = s;
            s = ref_lfsr(s);
        end

        @(posedge clk); #1;
        a_start = 1'b1; a_seed = seed; a_golden = golden;
        a_dut_rdy = m_rdy[0]; a_dut_px = m_px[0];
        for (int c = 1; c <= done_c; c++) begin
            @(posedge clk); #1;
            a_start = 1'b0; a_dut_rdy = m_rdy[c]; a_dut_px = m_px[c];
            @(negedge clk);
            idx     = (c - 1) / (A_G + 1);
            exp_rdy = ((c - 1) % (A_G + 1) == 0) && (idx < A_F) && (c < done_c);
            check("a_ctl{busy,done,rdy}", {29'd0, a_busy, a_done, a_px_rdy},
                  {29'd0, (c < done_c), (c == done_c), exp_rdy});
            if (exp_rdy) check("a_px", {24'd0, a_px}, {24'd0, exp_px[idx]});
        end
        check("a_sig", {16'd0, a_sig}, {16'd0, sig});
        check("a_flags{to,ov,pass}", {29'd0, a_to, a_ov, a_pass}, {29'd0, to, ov, pass});
        $display("[TB] run mode=%0d seed=%h done@%0d sig=%h to=%0d ov=%0d pass=%0d",
                 mode, seed, done_c, sig, to, ov, pass);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seed_vec_t  tbl [6];
        logic [7:0] seq01 [6];
        logic [7:0] b_exp [3];

        tbl[0] = '{seed: 8'h01, px0: 8'h01, px1: 8'hB8};
        tbl[1] = '{seed: 8'h00, px0: 8'h01, px1: 8'hB8};
        tbl[2] = '{seed: 8'hB8, px0: 8'hB8, px1: 8'h5C};
        tbl[3] = '{seed: 8'hFF, px0: 8'hFF, px1: 8'hC7};
        tbl[4] = '{seed: 8'h80, px0: 8'h80, px1: 8'h40};
        tbl[5] = '{seed: 8'h03, px0: 8'h03, px1: 8'hB9};
        seq01  = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        b_exp  = '{8'h5A, 8'h2D, 8'hAE};

        reset = 1'b1;
        a_start = 0; a_abort = 0; a_seed = 0; a_golden = 0; a_dut_rdy = 0; a_dut_px = 0;
        b_start = 0; b_abort = 0; b_seed = 0; b_golden = 0; b_dut_rdy = 0; b_dut_px = 0;
        c_start = 0; c_abort = 0; c_seed = 0; c_golden = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_a_outputs", {a_px, a_px_rdy, a_busy, a_done, a_pass, a_to, a_ov, a_sig},
              32'd0);
        check("reset_c_outputs", {c_px, c_px_rdy, c_busy, c_done, c_pass, c_to, c_ov, c_sig},
              32'd0);

        // Beats while IDLE are ignored.
        @(posedge clk); #1 a_dut_rdy = 1'b1; a_dut_px = 8'h5A;
        repeat (3) @(posedge clk);
        #1 a_dut_rdy = 1'b0;
        @(negedge clk);
        check("idle_beats_ignored{ov,sig}", {15'd0, a_ov, a_sig}, 32'd0);

        // Table: first two pixels per seed, then abort mid-RUN.
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1 a_start = 1'b1; a_seed = tbl[t].seed;
            @(posedge clk); #1 a_start = 1'b0;
            @(negedge clk);
            check("tbl_px0", {23'd0, a_px_rdy, a_px}, {23'd0, 1'b1, tbl[t].px0});
            @(posedge clk); #1;
            @(negedge clk);
            check("tbl_px1", {23'd0, a_px_rdy, a_px}, {23'd0, 1'b1, tbl[t].px1});
            @(posedge clk); #1 a_abort = 1'b1;
            @(posedge clk); #1 a_abort = 1'b0;
            @(negedge clk);
            check("abort{busy,rdy,done}", {29'd0, a_busy, a_px_rdy, a_done}, 32'd0);
            $display("[TB] table seed=%h px0=%h px1=%h", tbl[t].seed, tbl[t].px0, tbl[t].px1);
        end

        // Full six-pixel frame from seed 01 on consecutive cycles.
        @(posedge clk); #1 a_start = 1'b1; a_seed = 8'h01;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1 a_start = 1'b0;
            @(negedge clk);
            if (c <= 6) check("seq01_px", {23'd0, a_px_rdy, a_px}, {23'd0, 1'b1, seq01[c-1]});
            else        check("seq01_end_rdy", {31'd0, a_px_rdy}, 32'd0);
        end
        @(posedge clk); #1 a_abort = 1'b1;
        @(posedge clk); #1 a_abort = 1'b0;
        $display("[TB] seq01 frame issued");

        // Directed multi-cycle corner cases, then random back-to-back runs.
        run_a(1, 8'h37, 1'b1);
        run_a(2, 8'h11, 1'b1);
        run_a(3, 8'h00, 1'b1);
        run_a(4, 8'hC3, 1'b1);
        run_a(4, 8'hC3, 1'b0);
        for (int r = 0; r < 30; r++) begin
            run_a(0, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), $urandom_range(0, 1) == 1);
        end

        // Gap 2 frame: strobes at +1, +4, +7, DRAIN from +8, timeout after 4 quiet cycles.
        @(posedge clk); #1 b_start = 1'b1; b_seed = 8'h5A; b_golden = 16'h0000;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1 b_start = 1'b0;
            @(negedge clk);
            check("b_ctl{busy,done,rdy}", {29'd0, b_busy, b_done, b_px_rdy},
                  {29'd0, (c < 12), (c == 12), (c == 1 || c == 4 || c == 7)});
            if (c == 1 || c == 4 || c == 7)
                check("b_px", {24'd0, b_px}, {24'd0, b_exp[(c-1)/3]});
        end
        check("b_flags{to,ov,pass}", {29'd0, b_to, b_ov, b_pass}, {29'd0, 3'b100});
        $display("[TB] gap2 frame done at +12");

        // Single-pixel loopback: signature 0001, pass depends on golden.
        for (int g = 0; g < 2; g++) begin
            @(posedge clk); #1 c_start = 1'b1; c_seed = 8'h01;
            c_golden = (g == 0) ? 16'h0001 : 16'h0002;
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk); #1 c_start = 1'b0;
                @(negedge clk);
                check("c_ctl{busy,done}", {30'd0, c_busy, c_done}, {30'd0, (c < 3), (c == 3)});
            end
            check("c_sig", {16'd0, c_sig}, 32'h0001);
            check("c_pass", {31'd0, c_pass}, {31'd0, (g == 0)});
            $display("[TB] loopback golden=%h", c_golden);
        end

        // abort wins over start while in DONE.
        @(posedge clk); #1 c_start = 1'b1; c_abort = 1'b1;
        @(posedge clk); #1 c_start = 1'b0; c_abort = 1'b0;
        @(negedge clk);
        check("abort_over_start{busy,done,rdy}", {29'd0, c_busy, c_done, c_px_rdy}, 32'd0);
        $display("[TB] abort with start in DONE");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
